mem_access_ctrl: RTL and testbench

Data-memory access sequencer for the MIPS pipeline MEM stage. Takes the load/store request held in the EX/MEM pipeline register, runs a request/acknowledge transaction to a variable-latency data memory, and stalls the front of the pipeline until the access completes. It feeds the MEM/WB register with load data and a bubble control that squashes writeback while an access is in flight or has faulted.

---
 rtl/mem_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory access sequencer for a MIPS pipeline. A load or store
// held in EX/MEM is turned into a single request/acknowledge transaction to a
// variable-latency data memory. The front of the pipeline is stalled while the
// access is in flight, and writeback is squashed for faulted or pending work.
//
// Ports:
//   i_Clk, Reset                 rising-edge clock, async active-high reset
//   i_MemRead, i_MemWrite        load / store request from EX/MEM
//   i_Addr, i_WriteData          byte address and store data from EX/MEM
//   o_MemReq, o_MemWe            one-cycle request strobe and write flag
//   o_MemAddr, o_MemWData        address / store data latched at acceptance
//   i_MemAck, i_MemRData         memory acknowledge and read data
//   o_ReadData                   captured load data toward MEM/WB
//   o_Stall                      hold PC, IF/ID, ID/EX, EX/MEM
//   o_Bubble                     force RegWrite = MemtoReg = 0 into MEM/WB
//   o_Fault, i_FaultClr          sticky fault flag and its clear
//   o_StallCnt                   saturating count of stalled cycles
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             i_Clk,
  input  logic             Reset,
  input  logic             i_MemRead,
  input  logic             i_MemWrite,
  input  logic [31:0]      i_Addr,
  input  logic [31:0]      i_WriteData,
  output logic             o_MemReq,
  output logic             o_MemWe,
  output logic [31:0]      o_MemAddr,
  output logic [31:0]      o_MemWData,
  input  logic             i_MemAck,
  input  logic [31:0]      i_MemRData,
  output logic [31:0]      o_ReadData,
  output logic             o_Stall,
  output logic             o_Bubble,
  output logic             o_Fault,
  input  logic             i_FaultClr,
  output logic [CNT_W-1:0] o_StallCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       timed_out;     // high during a DONE cycle reached by timeout
  logic       mem_op;
  logic       access_ok;
  logic       accept;
  logic       capture;
  logic       timeout_hit;
  logic       set_fault;
  logic       stall_c;
  logic       bubble_c;

  assign mem_op    = i_MemRead | i_MemWrite;
  assign access_ok = (i_Addr[1:0] == 2'b00) & ~(i_MemRead & i_MemWrite);

  // Next-state decode plus the per-cycle stall/bubble/fault controls
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_c      = 1'b0;
    bubble_c     = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    set_fault    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          bubble_c = 1'b1;
          if (access_ok && !o_Fault) begin
            stall_c   = 1'b1;
            accept    = 1'b1;
            state_nxt = REQ;
          end else begin
            // squashed without a request; only a bad access raises the fault
            set_fault = ~access_ok;
          end
        end else begin
          bubble_c = 1'b0;
        end
      end
      REQ: begin
        stall_c      = 1'b1;
        bubble_c     = 1'b1;
        wait_cnt_nxt = 8'd0;
        if (i_MemAck) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (i_MemAck) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt_nxt == TIMEOUT_V) begin
            timeout_hit = 1'b1;
            set_fault   = 1'b1;
            state_nxt   = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      DONE: begin
        bubble_c  = timed_out;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stall and bubble are forced low for as long as reset is held
  assign o_Stall  = stall_c & ~Reset;
  assign o_Bubble = bubble_c & ~Reset;

  // Sequencer state, wait counter and timeout marker
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timed_out <= timeout_hit;
    end
  end

  // Memory-side request strobe and latched address/data
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      o_MemReq   <= 1'b0;
      o_MemWe    <= 1'b0;
      o_MemAddr  <= 32'd0;
      o_MemWData <= 32'd0;
    end else begin
      // accept only fires in IDLE, so the strobe covers exactly the REQ cycle
      o_MemReq <= accept;
      if (accept) begin
        o_MemWe    <= i_MemWrite;
        o_MemAddr  <= i_Addr;
        o_MemWData <= i_WriteData;
      end
    end
  end

  // Load data capture; a timed-out access returns zero
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      o_ReadData <= 32'd0;
    end else if (capture && !o_MemWe) begin
      o_ReadData <= i_MemRData;
    end else if (timeout_hit) begin
      o_ReadData <= 32'd0;
    end
  end

  // Sticky fault flag; a new fault wins over a simultaneous clear
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      o_Fault <= 1'b0;
    end else if (set_fault) begin
      o_Fault <= 1'b1;
    end else if (i_FaultClr) begin
      o_Fault <= 1'b0;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge i_Clk or posedge Reset) begin
    if (Reset) begin
      o_StallCnt <= {CNT_W{1'b0}};
    end else if (o_Stall && (o_StallCnt != {CNT_W{1'b1}})) begin
      o_StallCnt <= o_StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A transaction-level reference model
// predicts stall length, request count, bubble, load data, fault and stall
// count for each instruction from the access rules; a second instance with a
// 4-bit stall counter shares the stimulus to exercise saturation.
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic        i_Clk = 1'b0;
  logic        Reset;
  logic        i_MemRead, i_MemWrite, i_MemAck, i_FaultClr;
  logic [31:0] i_Addr, i_WriteData, i_MemRData;
  logic        o_MemReq, o_MemWe, o_Stall, o_Bubble, o_Fault;
  logic [31:0] o_MemAddr, o_MemWData, o_ReadData;
  logic [15:0] o_StallCnt;
  logic        req4, we4, stall4, bubble4, fault4;
  logic [31:0] addr4, wdata4, rdata4;
  logic [3:0]  cnt4;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          m_fault;
  logic [31:0] m_rdata;
  int          m_cnt;
  // model predictions for the current instruction
  int          exp_stalls, exp_reqs;
  bit          exp_bubble, exp_fault_final, exp_fault_after;
  logic [31:0] exp_rdata;
  // observations of the current instruction
  int          obs_stalls, obs_reqs;
  bit          obs_bubble, obs_fault, obs_fault_after, obs_bub_ok, obs_done, obs_trail_quiet;
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [15:0] obs_cnt;
  logic [3:0]  obs_cnt4;

  mem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .i_Clk(i_Clk), .Reset(Reset), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_Addr(i_Addr), .i_WriteData(i_WriteData), .o_MemReq(o_MemReq), .o_MemWe(o_MemWe),
    .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData), .i_MemAck(i_MemAck),
    .i_MemRData(i_MemRData), .o_ReadData(o_ReadData), .o_Stall(o_Stall),
    .o_Bubble(o_Bubble), .o_Fault(o_Fault), .i_FaultClr(i_FaultClr), .o_StallCnt(o_StallCnt)
  );

  mem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(4)) dut4 (
    .i_Clk(i_Clk), .Reset(Reset), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_Addr(i_Addr), .i_WriteData(i_WriteData), .o_MemReq(req4), .o_MemWe(we4),
    .o_MemAddr(addr4), .o_MemWData(wdata4), .i_MemAck(i_MemAck),
    .i_MemRData(i_MemRData), .o_ReadData(rdata4), .o_Stall(stall4),
    .o_Bubble(bubble4), .o_Fault(fault4), .i_FaultClr(i_FaultClr), .o_StallCnt(cnt4)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference model: one call per instruction, outcome from the access rules.
  // ack_at: 0 = ack in the request cycle, n = ack on the n-th wait cycle, -1 = never.
  task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input int ack_at, input logic [31:0] rdat, input bit clr);
    bit mem, ok;
    mem = rd | wr;
    ok  = (addr[1:0] == 2'b00) && !(rd && wr);
    exp_reqs = 0; exp_stalls = 0; exp_bubble = 1'b0;
    if (!mem) begin
      exp_fault_final = m_fault;
      if (clr) m_fault = 1'b0;
    end else if (!ok || m_fault) begin
      exp_bubble = 1'b1;
      exp_fault_final = m_fault;
      if (!ok) m_fault = 1'b1;
      else if (clr) m_fault = 1'b0;
    end else begin
      exp_reqs = 1;
      if (ack_at >= 0 && ack_at <= TMO) begin
        exp_stalls = 2 + ack_at;
        if (rd) m_rdata = rdat;
      end else begin
        exp_stalls = 2 + TMO;
        exp_bubble = 1'b1;
        m_rdata = 32'd0;
        m_fault = 1'b1;
      end
      exp_fault_final = m_fault;
    end
    exp_fault_after = m_fault;
    exp_rdata = m_rdata;
    m_cnt += exp_stalls;
    if (m_cnt > 65535) m_cnt = 65535;
  endtask

  task automatic model_reset;
    m_fault = 1'b0; m_rdata = 32'd0; m_cnt = 0;
  endtask

  // Pipeline/memory driver: holds the instruction until stall drops, acks as asked,
  // then optionally spends one idle cycle (trail) with a late ack if scheduled there.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at,
                            input logic [31:0] rdat, input bit clr, input bit trail);
    int req_cyc, last;
    req_cyc = -1; last = 0;
    obs_stalls = 0; obs_reqs = 0; obs_bub_ok = 1'b1; obs_done = 1'b0;
    for (int c = 0; c < 64 && !obs_done; c++) begin
      @(negedge i_Clk);
      if (c == 0) begin
        i_MemRead = rd; i_MemWrite = wr; i_Addr = addr; i_WriteData = wdata;
      end
      i_FaultClr = (c == 0) ? clr : 1'b0;
      if (o_MemReq) begin
        obs_reqs++; req_cyc = c;
        obs_we = o_MemWe; obs_addr = o_MemAddr; obs_wdata = o_MemWData;
      end
      i_MemAck   = (req_cyc >= 0 && ack_at >= 0 && (c - req_cyc) == ack_at);
      i_MemRData = i_MemAck ? rdat : $urandom;
      #1;
      if (o_Stall) begin
        obs_stalls++;
        if (!o_Bubble) obs_bub_ok = 1'b0;
      end else begin
        obs_done = 1'b1; last = c;
        obs_bubble = o_Bubble; obs_rdata = o_ReadData; obs_fault = o_Fault;
        obs_cnt = o_StallCnt; obs_cnt4 = cnt4;
      end
    end
    vectors++;
    if (!obs_done) begin
      miscompares++;
      $display("FAIL access_done: stall still high after %0d cycles, required to drop", obs_stalls);
    end
    if (trail) begin
      @(negedge i_Clk);
      i_MemRead = 1'b0; i_MemWrite = 1'b0; i_FaultClr = 1'b0;
      i_MemAck = (req_cyc >= 0 && ack_at >= 0 && (last + 1 - req_cyc) == ack_at);
      #1;
      obs_fault_after = o_Fault;
      obs_trail_quiet = !o_Stall && !o_Bubble && !o_MemReq;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Addr = 32'h100;
    i_WriteData = 32'hA5A5A5A5; i_MemAck = 1'b1; i_MemRData = 32'h1; i_FaultClr = 1'b0;
    repeat (2) @(negedge i_Clk);
    #1;
    vectors++;
    if ({o_Stall, o_Bubble, o_MemReq, o_MemWe, o_Fault} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: stall/bubble/req/we/fault=%b required 00000",
               {o_Stall, o_Bubble, o_MemReq, o_MemWe, o_Fault});
    end
    vectors++;
    if ({o_MemAddr, o_MemWData, o_ReadData, o_StallCnt} !== 112'd0) begin
      miscompares++;
      $display("FAIL reset_regs: addr=%h wdata=%h rdata=%h cnt=%0d required all 0",
               o_MemAddr, o_MemWData, o_ReadData, o_StallCnt);
    end
    @(negedge i_Clk);
    Reset = 1'b0; i_MemRead = 1'b0; i_MemAck = 1'b0;
    model_reset();
  endtask

  task automatic test_load_fast;
    model_access(1'b1, 1'b0, 32'h100, 0, 32'hDEADBEEF, 1'b0);
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b1);
    vectors++; if (obs_stalls !== 2) begin miscompares++; $display("FAIL load_fast.stalls got %0d want 2", obs_stalls); end
    vectors++; if (obs_reqs !== 1 || obs_we !== 1'b0 || obs_addr !== 32'h100) begin miscompares++;
      $display("FAIL load_fast.req got reqs=%0d we=%b addr=%h want 1/0/100", obs_reqs, obs_we, obs_addr); end
    vectors++; if (obs_rdata !== 32'hDEADBEEF || obs_bubble !== 1'b0) begin miscompares++;
      $display("FAIL load_fast.done got rdata=%h bubble=%b want deadbeef/0", obs_rdata, obs_bubble); end
    vectors++; if (int'(obs_cnt) !== m_cnt) begin miscompares++; $display("FAIL load_fast.cnt got %0d want %0d", obs_cnt, m_cnt); end
  endtask

  task automatic test_store_wait;
    model_access(1'b0, 1'b1, 32'h204, 3, 32'h0BADF00D, 1'b0);
    run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 3, 32'h0BADF00D, 1'b0, 1'b1);
    vectors++; if (obs_stalls !== 5) begin miscompares++; $display("FAIL store_wait.stalls got %0d want 5", obs_stalls); end
    vectors++; if (obs_we !== 1'b1 || obs_addr !== 32'h204 || obs_wdata !== 32'h12345678) begin miscompares++;
      $display("FAIL store_wait.req got we=%b addr=%h wdata=%h want 1/204/12345678", obs_we, obs_addr, obs_wdata); end
    vectors++; if (obs_rdata !== exp_rdata) begin miscompares++; $display("FAIL store_wait.rdata got %h want %h", obs_rdata, exp_rdata); end
    vectors++; if (int'(obs_cnt) !== m_cnt) begin miscompares++; $display("FAIL store_wait.cnt got %0d want %0d", obs_cnt, m_cnt); end
  endtask

  task automatic test_timeout;
    // late ack lands two cycles after the last wait cycle (the idle cycle after DONE)
    model_access(1'b1, 1'b0, 32'h300, TMO + 2, 32'h77777777, 1'b0);
    run_access(1'b1, 1'b0, 32'h300, 32'h0, TMO + 2, 32'h77777777, 1'b0, 1'b1);
    vectors++; if (obs_stalls !== 2 + TMO) begin miscompares++; $display("FAIL timeout.stalls got %0d want %0d", obs_stalls, 2 + TMO); end
    vectors++; if (obs_bubble !== 1'b1 || obs_rdata !== 32'd0 || obs_fault !== 1'b1) begin miscompares++;
      $display("FAIL timeout.done got bubble=%b rdata=%h fault=%b want 1/0/1", obs_bubble, obs_rdata, obs_fault); end
    vectors++; if (!obs_trail_quiet) begin miscompares++; $display("FAIL timeout.late_ack got activity want quiet"); end
    model_access(1'b1, 1'b0, 32'h100, 0, 32'h11111111, 1'b0);
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h11111111, 1'b0, 1'b1);
    vectors++; if (obs_reqs !== 0 || obs_stalls !== 0 || obs_bubble !== 1'b1 || obs_rdata !== 32'd0) begin miscompares++;
      $display("FAIL timeout.squash got reqs=%0d stalls=%0d bubble=%b rdata=%h want 0/0/1/0", obs_reqs, obs_stalls, obs_bubble, obs_rdata); end
    model_access(1'b0, 1'b0, 32'h0, -1, 32'h0, 1'b1);
    run_access(1'b0, 1'b0, 32'h0, 32'h0, -1, 32'h0, 1'b1, 1'b1);
    vectors++; if (obs_fault_after !== 1'b0) begin miscompares++; $display("FAIL timeout.clear got fault=%b want 0", obs_fault_after); end
    model_access(1'b1, 1'b0, 32'h108, 1, 32'h22222222, 1'b0);
    run_access(1'b1, 1'b0, 32'h108, 32'h0, 1, 32'h22222222, 1'b0, 1'b1);
    vectors++; if (obs_reqs !== 1 || obs_stalls !== 3 || obs_rdata !== 32'h22222222) begin miscompares++;
      $display("FAIL timeout.resume got reqs=%0d stalls=%0d rdata=%h want 1/3/22222222", obs_reqs, obs_stalls, obs_rdata); end
  endtask

  task automatic test_misaligned;
    model_access(1'b1, 1'b0, 32'h102, 0, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    vectors++; if (obs_reqs !== 0 || obs_stalls !== 0 || obs_bubble !== 1'b1 || obs_fault_after !== 1'b1) begin miscompares++;
      $display("FAIL misaligned got reqs=%0d stalls=%0d bubble=%b fault=%b want 0/0/1/1", obs_reqs, obs_stalls, obs_bubble, obs_fault_after); end
    model_access(1'b0, 1'b1, 32'h203, 0, 32'h0, 1'b1);
    run_access(1'b0, 1'b1, 32'h203, 32'h5, 0, 32'h0, 1'b1, 1'b1);
    vectors++; if (obs_fault_after !== exp_fault_after) begin miscompares++;
      $display("FAIL misaligned.set_wins got fault=%b want %b", obs_fault_after, exp_fault_after); end
    model_access(1'b0, 1'b0, 32'h0, -1, 32'h0, 1'b1);
    run_access(1'b0, 1'b0, 32'h0, 32'h0, -1, 32'h0, 1'b1, 1'b1);
    model_access(1'b1, 1'b1, 32'h400, 0, 32'h0, 1'b0);
    run_access(1'b1, 1'b1, 32'h400, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    vectors++; if (obs_reqs !== 0 || obs_fault_after !== 1'b1) begin miscompares++;
      $display("FAIL rd_and_wr got reqs=%0d fault=%b want 0/1", obs_reqs, obs_fault_after); end
    model_access(1'b0, 1'b0, 32'h0, -1, 32'h0, 1'b1);
    run_access(1'b0, 1'b0, 32'h0, 32'h0, -1, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid;
    @(negedge i_Clk);
    i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Addr = 32'h40; i_MemAck = 1'b0; i_FaultClr = 1'b0;
    repeat (4) @(negedge i_Clk);
    #1;
    vectors++; if (o_Stall !== 1'b1) begin miscompares++; $display("FAIL reset_mid.inflight got stall=%b want 1", o_Stall); end
    #1; Reset = 1'b1; #1;
    vectors++;
    if ({o_MemReq, o_Stall, o_Bubble, o_MemWe, o_Fault} !== 5'b0 ||
        {o_MemAddr, o_MemWData, o_ReadData, o_StallCnt} !== 112'd0) begin
      miscompares++;
      $display("FAIL reset_mid.async got req=%b stall=%b bubble=%b addr=%h cnt=%0d want all 0",
               o_MemReq, o_Stall, o_Bubble, o_MemAddr, o_StallCnt);
    end
    @(negedge i_Clk);
    Reset = 1'b0; i_MemRead = 1'b0; i_MemAck = 1'b1; i_MemRData = $urandom;
    @(negedge i_Clk);
    i_MemAck = 1'b0; #1;
    vectors++;
    if ({o_MemReq, o_Stall, o_Bubble} !== 3'b0 || o_ReadData !== 32'd0 || o_StallCnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid.stray_ack got req=%b stall=%b rdata=%h cnt=%0d want 0/0/0/0",
               o_MemReq, o_Stall, o_ReadData, o_StallCnt);
    end
    model_reset();
  endtask

  task automatic test_stall_sat;
    for (int i = 0; i < 3; i++) begin
      model_access(1'b0, 1'b0, $urandom, -1, 32'h0, 1'b0);
      run_access(1'b0, 1'b0, $urandom, $urandom, -1, 32'h0, 1'b0, 1'b0);
      vectors++; if (obs_stalls !== 0 || obs_bubble !== 1'b0) begin miscompares++;
        $display("FAIL alu_pass got stalls=%0d bubble=%b want 0/0", obs_stalls, obs_bubble); end
    end
    for (int i = 0; i < 4; i++) begin
      model_access(1'b1, 1'b0, 32'h80, 3, 32'hC0DE0000 + i, 1'b0);
      run_access(1'b1, 1'b0, 32'h80, 32'h0, 3, 32'hC0DE0000 + i, 1'b0, 1'b0);
      vectors++; if (int'(obs_cnt4) !== ((m_cnt > 15) ? 15 : m_cnt) || int'(obs_cnt) !== m_cnt) begin miscompares++;
        $display("FAIL stall_sat got cnt4=%0d cnt=%0d want %0d/%0d", obs_cnt4, obs_cnt, (m_cnt > 15) ? 15 : m_cnt, m_cnt); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      model_access(1'b1, 1'b0, 32'h500 + 32'(4 * i), i, d, 1'b0);
      run_access(1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'h0, i, d, 1'b0, 1'b0);
      vectors++; if (obs_reqs !== 1 || obs_stalls !== exp_stalls || obs_rdata !== exp_rdata) begin miscompares++;
        $display("FAIL back_to_back got reqs=%0d stalls=%0d rdata=%h want 1/%0d/%h", obs_reqs, obs_stalls, obs_rdata, exp_stalls, exp_rdata); end
    end
  endtask

  task automatic test_random;
    bit rd, wr, clr, trail;
    int op, ack_at, sel;
    logic [31:0] a, wd, rdat;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      rd = (op >= 2 && op <= 5) || op == 9;
      wr = (op >= 6);
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      sel = $urandom_range(0, 9);
      if (sel < 7)       ack_at = $urandom_range(0, 4);
      else if (sel == 7) ack_at = TMO;
      else if (sel == 8) ack_at = -1;
      else               ack_at = $urandom_range(5, 12);
      wd = $urandom; rdat = $urandom;
      clr = ($urandom_range(0, 3) == 0);
      trail = $urandom_range(0, 1) != 0;
      model_access(rd, wr, a, ack_at, rdat, clr);
      run_access(rd, wr, a, wd, ack_at, rdat, clr, trail);
      vectors++;
      if (obs_stalls !== exp_stalls || obs_reqs !== exp_reqs || obs_bubble !== exp_bubble || !obs_bub_ok) begin
        miscompares++;
        $display("FAIL rand[%0d].flow got stalls=%0d reqs=%0d bubble=%b bub_ok=%b want %0d/%0d/%b/1",
                 n, obs_stalls, obs_reqs, obs_bubble, obs_bub_ok, exp_stalls, exp_reqs, exp_bubble);
      end
      vectors++;
      if (obs_rdata !== exp_rdata || obs_fault !== exp_fault_final || int'(obs_cnt) !== m_cnt ||
          int'(obs_cnt4) !== ((m_cnt > 15) ? 15 : m_cnt)) begin
        miscompares++;
        $display("FAIL rand[%0d].result got rdata=%h fault=%b cnt=%0d cnt4=%0d want %h/%b/%0d/%0d",
                 n, obs_rdata, obs_fault, obs_cnt, obs_cnt4, exp_rdata, exp_fault_final, m_cnt, (m_cnt > 15) ? 15 : m_cnt);
      end
      if (exp_reqs == 1 && obs_reqs == 1) begin
        vectors++;
        if (obs_we !== wr || obs_addr !== a || (wr && obs_wdata !== wd)) begin
          miscompares++;
          $display("FAIL rand[%0d].req got we=%b addr=%h wdata=%h want %b/%h/%h", n, obs_we, obs_addr, obs_wdata, wr, a, wd);
        end
      end
      if (trail) begin
        vectors++;
        if (obs_fault_after !== exp_fault_after) begin
          miscompares++;
          $display("FAIL rand[%0d].fault_after got %b want %b", n, obs_fault_after, exp_fault_after);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_fast();
    test_store_wait();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_stall_sat();
    test_back_to_back();
    test_random();
    @(negedge i_Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
